obstacle_scheduler: RTL and testbench
=====================================

// Module: obstacle_scheduler
// PURPOSE
//  Sequences the obstacle field once per frame: on each movement step it erases, moves, spawns and redraws obstacles.
//  - Timing comes from the 1/60 s delay_counter tick and the frame_counter step pulse.
//  - Spawn lane and spawn gap come from fibonacci_lfsr_5bit.
//  - Drives the pixel drawer over a valid/ready handshake; the drawer is shared, so obstacles are issued one at a time.
// PARAMETERS
//  SLOTS      4      obstacle slots, 1..8
//  X_START    8'd159 x loaded into a newly spawned obstacle (right screen edge)
//  SPAWN_GAP  6'd40  minimum number of steps between spawns
// PORTS
//  clock        in   1  system clock, 50 MHz
//  resetn       in   1  synchronous, active-low reset
//  enable       in   1  game running; blocks new passes when low
//  tick         in   1  1-cycle 1/60 s pulse (delay_counter go)
//  step         in   1  movement due (frame_counter next); sampled only with tick
//  rand_in      in   5  LFSR value; [1:0]=lane, [4:2]=extra gap
//  draw_ready   in   1  drawer accepts the current request
//  draw_valid   out  1  request to drawer
//  draw_erase   out  1  1=erase obstacle, 0=draw obstacle
//  draw_x       out  8  obstacle x
//  draw_lane    out  2  obstacle lane
//  slot_active  out  SLOTS  per-slot occupied flags
//  busy         out  1  FSM not in IDLE
//  overrun      out  1  1-cycle pulse: tick&step arrived while busy (pass dropped)
// BEHAVIOUR
//  Reset (resetn=0 at posedge), including mid-pass:
//  - FSM=IDLE; all slots inactive, x=0, lane=0.
//  - gap counter=SPAWN_GAP; all outputs 0.
//  - draw_valid falls at that edge; a pending request is abandoned.
//  FSM states: IDLE -> ERASE -> MOVE -> SPAWN -> DRAW -> IDLE.
//  IDLE:
//  - enable & tick & step -> ERASE at the next edge.
//  - tick without step: no action.
//  ERASE:
//  - Walk active slots in ascending index order.
//  - draw_valid=1, draw_erase=1, with that slot's x/lane.
//  - Advance on the edge where draw_valid&draw_ready.
//  - Inactive slots are skipped with zero cycles each.
//  - After the last active slot (or none active) -> MOVE at the next edge.
//  MOVE (1 cycle):
//  - Every active slot with x!=0 gets x-1; an active slot with x==0 is cleared (exits screen).
//  - If gap!=0 then gap-1.
//  SPAWN (1 cycle):
//  - If gap==0 and a free slot exists: the lowest-index free slot becomes active.
//    x=X_START, lane=rand_in[1:0]; gap reloads SPAWN_GAP+rand_in[4:2] (7-bit add, no overflow).
//  - If gap==0 and all slots are full: no spawn; gap stays 0 and spawning retries next pass.
//  DRAW: same as ERASE with draw_erase=0, using the post-move/spawn contents; then -> IDLE.
//  Handshake rules:
//  - draw_valid, once high, holds with draw_erase/draw_x/draw_lane stable until accepted.
//  - Never more than 1 outstanding request; outputs are registered.
//  - draw_ready while draw_valid=0 is ignored.
//  Latency: the tick edge enters ERASE; first draw_valid is high in the following cycle.
//  enable low mid-pass: the current pass completes normally to IDLE.
//  overrun: tick&step while busy pulses overrun for 1 cycle; state is unaffected.
//  busy=1 in every state but IDLE. slot_active reflects register state directly.
// TESTING
//  1. Reset, then 1 pass, no slots, gap=40 -> no draw_valid; pass takes 4 cycles; gap=39.
//  2. Run 40 passes with rand_in=5'b10110 -> slot0 spawns x=159, lane=2; gap=45; DRAW issues (159,lane2,erase=0).
//  3. Next pass, draw_ready held low 5 cycles -> erase(159,2) held stable 5 cycles; then draw at x=158.
//  4. Slot at x=0 during MOVE -> slot cleared; DRAW skips it; slot_active bit drops.
//  5. Fill all 4 slots, gap reaches 0 -> no spawn, gap stays 0; next free slot spawns on the first pass after a clear.
//  6. tick&step during DRAW -> overrun 1 cycle, no extra pass. resetn=0 during ERASE with draw_valid=1 -> all outputs 0 next cycle.

Source files
------------

// File: rtl/obstacle_scheduler.sv
// Obstacle field sequencer: per movement step erases, moves, spawns and redraws obstacle slots.
// Latency: the tick&step edge enters ERASE; the first draw request is presented one cycle later.
// Backpressure: one drawer request at a time, held stable until draw_ready; the pass stalls meanwhile.
module obstacle_scheduler #(
    parameter int         SLOTS     = 4,
    parameter logic [7:0] X_START   = 8'd159,
    parameter logic [5:0] SPAWN_GAP = 6'd40
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             enable,
    input  logic             tick,
    input  logic             step,
    input  logic [4:0]       rand_in,
    input  logic             draw_ready,
    output logic             draw_valid,
    output logic             draw_erase,
    output logic [7:0]       draw_x,
    output logic [1:0]       draw_lane,
    output logic [SLOTS-1:0] slot_active,
    output logic             busy,
    output logic             overrun
);

    localparam int IW = (SLOTS > 1) ? $clog2(SLOTS) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ERASE,
        S_MOVE,
        S_SPAWN,
        S_DRAW
    } state_t;

    state_t           state;
    logic [7:0]       x_q    [SLOTS];
    logic [1:0]       lane_q [SLOTS];
    logic [SLOTS-1:0] active_q;
    logic [SLOTS-1:0] pending_q;   // slots still to be issued in the current ERASE/DRAW walk
    logic [6:0]       gap_q;

    logic             pend_any;
    logic [IW-1:0]    pend_idx;
    logic [SLOTS-1:0] pend_rest;
    logic             free_any;
    logic [IW-1:0]    free_idx;
    logic             spawn_ok;
    logic [SLOTS-1:0] spawn_active;

    assign slot_active = active_q;

    // Lowest pending slot (next request) and lowest free slot (spawn target).
    always_comb begin
        pend_any = 1'b0;
        pend_idx = '0;
        free_any = 1'b0;
        free_idx = '0;
        for (int i = SLOTS - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                pend_any = 1'b1;
                pend_idx = IW'(i);
            end
            if (!active_q[i]) begin
                free_any = 1'b1;
                free_idx = IW'(i);
            end
        end
    end

    // Remaining walk mask after issuing pend_idx, and occupancy after a possible spawn.
    always_comb begin
        pend_rest = pending_q;
        if (pend_any) begin
            pend_rest[pend_idx] = 1'b0;
        end
        spawn_ok     = (gap_q == 7'd0) && free_any;
        spawn_active = active_q;
        if (spawn_ok) begin
            spawn_active[free_idx] = 1'b1;
        end
    end

    // Pass sequencer with registered drawer interface and slot storage.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state      <= S_IDLE;
            active_q   <= '0;
            pending_q  <= '0;
            gap_q      <= {1'b0, SPAWN_GAP};
            draw_valid <= 1'b0;
            draw_erase <= 1'b0;
            draw_x     <= 8'd0;
            draw_lane  <= 2'd0;
            busy       <= 1'b0;
            overrun    <= 1'b0;
            for (int i = 0; i < SLOTS; i++) begin
                x_q[i]    <= 8'd0;
                lane_q[i] <= 2'd0;
            end
        end else begin
            overrun <= (state != S_IDLE) && tick && step;
            case (state)
                S_IDLE: begin
                    if (enable && tick && step) begin
                        state     <= S_ERASE;
                        busy      <= 1'b1;
                        pending_q <= active_q;
                    end
                end
                S_ERASE, S_DRAW: begin
                    // Advance only when nothing is outstanding or the drawer takes it now.
                    if (!draw_valid || draw_ready) begin
                        if (pend_any) begin
                            draw_valid <= 1'b1;
                            draw_erase <= (state == S_ERASE);
                            draw_x     <= x_q[pend_idx];
                            draw_lane  <= lane_q[pend_idx];
                            pending_q  <= pend_rest;
                        end else begin
                            draw_valid <= 1'b0;
                            draw_erase <= 1'b0;
                            draw_x     <= 8'd0;
                            draw_lane  <= 2'd0;
                            if (state == S_ERASE) begin
                                state <= S_MOVE;
                            end else begin
                                state <= S_IDLE;
                                busy  <= 1'b0;
                            end
                        end
                    end
                end
                S_MOVE: begin
                    // Obstacles at the left edge leave the field instead of wrapping.
                    for (int i = 0; i < SLOTS; i++) begin
                        if (active_q[i]) begin
                            if (x_q[i] == 8'd0) begin
                                active_q[i] <= 1'b0;
                            end else begin
                                x_q[i] <= x_q[i] - 8'd1;
                            end
                        end
                    end
                    if (gap_q != 7'd0) begin
                        gap_q <= gap_q - 7'd1;
                    end
                    state <= S_SPAWN;
                end
                S_SPAWN: begin
                    // With all slots full the gap stays at zero so the next pass retries.
                    if (spawn_ok) begin
                        x_q[free_idx]    <= X_START;
                        lane_q[free_idx] <= rand_in[1:0];
                        gap_q            <= {1'b0, SPAWN_GAP} + {4'b0000, rand_in[4:2]};
                    end
                    active_q  <= spawn_active;
                    pending_q <= spawn_active;
                    state     <= S_DRAW;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_obstacle_scheduler.sv
// Bench for obstacle_scheduler: random passes scored against a slot-list model via an expected-request queue.
// A second instance with a long obstacle lifetime and short gap exercises the all-slots-full case.
// Drawer ready is randomised; a monitor pops one expected request per accepted handshake.
module tb_obstacle_scheduler;

    logic clock = 1'b0;
    always #10 clock = ~clock;

    logic       resetn, enable, tick, step, draw_ready;
    logic [4:0] rand_in;
    logic       dv0, de0, busy0, ovr0;
    logic [7:0] dx0;
    logic [1:0] dl0;
    logic [3:0] sa0;
    logic       dv1, de1, busy1, ovr1;
    logic [7:0] dx1;
    logic [1:0] dl1;
    logic [3:0] sa1;

    obstacle_scheduler u_dut (
        .clock(clock), .resetn(resetn), .enable(enable), .tick(tick), .step(step),
        .rand_in(rand_in), .draw_ready(draw_ready), .draw_valid(dv0), .draw_erase(de0),
        .draw_x(dx0), .draw_lane(dl0), .slot_active(sa0), .busy(busy0), .overrun(ovr0)
    );

    obstacle_scheduler #(.SLOTS(4), .X_START(8'd100), .SPAWN_GAP(6'd10)) u_full (
        .clock(clock), .resetn(resetn), .enable(enable), .tick(tick), .step(step),
        .rand_in(rand_in), .draw_ready(draw_ready), .draw_valid(dv1), .draw_erase(de1),
        .draw_x(dx1), .draw_lane(dl1), .slot_active(sa1), .busy(busy1), .overrun(ovr1)
    );

    typedef struct packed {
        logic       e;
        logic [7:0] x;
        logic [1:0] l;
    } req_t;

    int   total = 0;
    int   bad = 0;
    int   ready_pct = 100;
    bit   abort = 0;
    req_t q0[$];
    req_t q1[$];
    req_t prev_r[2];
    bit   hold[2];
    int   m_x[2][4];
    int   m_lane[2][4];
    bit   m_act[2][4];
    int   m_gap[2];
    int   full_seen[2];
    int   clear_seen[2];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int xs(input int d);
        return (d == 0) ? 159 : 100;
    endfunction

    function automatic int gs(input int d);
        return (d == 0) ? 40 : 10;
    endfunction

    function automatic logic [3:0] mvec(input int d);
        logic [3:0] v;
        for (int i = 0; i < 4; i++) v[i] = m_act[d][i];
        return v;
    endfunction

    task automatic push(input int d, input bit e, input int x, input int l);
        req_t r;
        r.e = e;
        r.x = 8'(x);
        r.l = 2'(l);
        if (d == 0) q0.push_back(r);
        else q1.push_back(r);
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 4; i++) begin
                m_x[d][i] = 0;
                m_lane[d][i] = 0;
                m_act[d][i] = 0;
            end
            m_gap[d] = gs(d);
        end
        q0.delete();
        q1.delete();
    endtask

    // One full pass on the slot list: erase all, move left, maybe spawn, draw all.
    task automatic model_pass(input int d, input int r, output int nreq);
        int fi;
        nreq = 0;
        for (int i = 0; i < 4; i++)
            if (m_act[d][i]) begin push(d, 1, m_x[d][i], m_lane[d][i]); nreq++; end
        for (int i = 0; i < 4; i++)
            if (m_act[d][i]) begin
                if (m_x[d][i] == 0) begin m_act[d][i] = 0; clear_seen[d]++; end
                else m_x[d][i] = m_x[d][i] - 1;
            end
        if (m_gap[d] > 0) m_gap[d] = m_gap[d] - 1;
        if (m_gap[d] == 0) begin
            fi = -1;
            for (int i = 3; i >= 0; i--) if (!m_act[d][i]) fi = i;
            if (fi >= 0) begin
                m_act[d][fi] = 1;
                m_x[d][fi] = xs(d);
                m_lane[d][fi] = r % 4;
                m_gap[d] = gs(d) + r / 4;
            end else begin
                full_seen[d]++;
            end
        end
        for (int i = 0; i < 4; i++)
            if (m_act[d][i]) begin push(d, 0, m_x[d][i], m_lane[d][i]); nreq++; end
    endtask

    task automatic mon(input int d, input logic v, input logic rdy, input req_t cur);
        req_t e;
        bit have;
        if (!resetn) begin
            hold[d] = 0;
            return;
        end
        if (hold[d]) begin
            total++;
            if (!v || cur != prev_r[d]) begin
                bad++;
                $display("FAIL hold_stable dut%0d: got v=%0b e=%0b x=%0d l=%0d required v=1 e=%0b x=%0d l=%0d",
                         d, v, cur.e, cur.x, cur.l, prev_r[d].e, prev_r[d].x, prev_r[d].l);
            end
        end
        if (v && rdy) begin
            have = 0;
            if (d == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1; end
            if (d == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1; end
            total++;
            if (!have) begin
                bad++;
                $display("FAIL unexpected_req dut%0d: got e=%0b x=%0d l=%0d required none", d, cur.e, cur.x, cur.l);
            end else if (cur != e) begin
                bad++;
                $display("FAIL req dut%0d: got e=%0b x=%0d l=%0d required e=%0b x=%0d l=%0d",
                         d, cur.e, cur.x, cur.l, e.e, e.x, e.l);
            end
            hold[d] = 0;
        end else begin
            hold[d] = v;
            prev_r[d] = cur;
        end
    endtask

    // Monitor: scores every accepted drawer request and checks held requests stay stable.
    always @(negedge clock) begin
        mon(0, dv0, draw_ready, {de0, dx0, dl0});
        mon(1, dv1, draw_ready, {de1, dx1, dl1});
    end

    // Drawer model: random ready at the configured acceptance rate.
    initial begin
        draw_ready = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            draw_ready = ($urandom_range(0, 99) < ready_pct);
        end
    end

    task automatic tick_pulse(input bit st);
        @(posedge clock);
        #1;
        tick = 1'b1;
        step = st;
        @(posedge clock);
        #1;
        tick = 1'b0;
        step = 1'b0;
    endtask

    task automatic run_pass(input logic [4:0] r, input bit chk_len, input bit do_ovr, input int hold_n);
        int n0, n1, c0, c1, k, ovr_at, held;
        if (abort) return;
        rand_in = r;
        model_pass(0, int'(r), n0);
        model_pass(1, int'(r), n1);
        ovr_at = do_ovr ? (((n0 < n1) ? n0 : n1) + 4) : -1;
        tick_pulse(1'b1);
        c0 = 0; c1 = 0; k = 0; held = 0;
        while ((busy0 || busy1) && k < 3000) begin
            k++;
            if (busy0) c0++;
            if (busy1) c1++;
            if (hold_n > 0 && dv0 && held < hold_n && q0.size() > 0) begin
                chk("hold_erase", de0, q0[0].e);
                chk("hold_x", dx0, q0[0].x);
                chk("hold_lane", dl0, q0[0].l);
                held++;
                if (held == hold_n) ready_pct = 100;
            end
            if (k == ovr_at) begin tick = 1'b1; step = 1'b1; end
            @(posedge clock);
            #1;
            if (k == ovr_at) begin
                tick = 1'b0;
                step = 1'b0;
                chk("overrun0_pulse", ovr0, 1);
                chk("overrun1_pulse", ovr1, 1);
            end
        end
        if (k >= 3000) begin
            total++;
            bad++;
            $display("FAIL pass_timeout: got busy after %0d cycles required idle", k);
            abort = 1;
            return;
        end
        if (hold_n > 0) chk("hold_cycles", held, hold_n);
        if (do_ovr) begin
            @(posedge clock);
            #1;
            chk("overrun0_end", ovr0, 0);
            chk("no_extra_pass0", busy0, 0);
            chk("no_extra_pass1", busy1, 0);
        end
        if (chk_len) begin
            chk("pass_len0", c0, n0 + 4);
            chk("pass_len1", c1, n1 + 4);
        end
        chk("slot_active0", sa0, mvec(0));
        chk("slot_active1", sa1, mvec(1));
    endtask

    initial begin
        int k, kind;
        resetn = 1'b0; enable = 1'b0; tick = 1'b0; step = 1'b0; rand_in = 5'd0;
        model_reset();
        repeat (3) @(posedge clock);
        #1;
        chk("rst_valid", dv0, 0);
        chk("rst_erase", de0, 0);
        chk("rst_x", dx0, 0);
        chk("rst_lane", dl0, 0);
        chk("rst_slots", sa0, 0);
        chk("rst_busy", busy0, 0);
        chk("rst_overrun", ovr0, 0);
        chk("rst_slots1", sa1, 0);
        resetn = 1'b1;
        enable = 1'b1;

        // Gap countdown to the first spawn, then a pass with the drawer stalled.
        for (int p = 0; p < 40; p++) run_pass(5'b10110, 1, 0, 0);
        ready_pct = 0;
        run_pass(5'b10110, 0, 0, 5);
        ready_pct = 100;

        // Idle ignores tick without step, and passes while disabled.
        tick_pulse(1'b0);
        chk("tick_no_step", busy0, 0);
        enable = 1'b0;
        tick_pulse(1'b1);
        chk("disabled0", busy0, 0);
        chk("disabled1", busy1, 0);
        enable = 1'b1;
        run_pass(5'($urandom_range(0, 31)), 1, 1, 0);

        for (int p = 0; p < 250 && !abort; p++) begin
            ready_pct = (p % 4 == 0) ? 100 : $urandom_range(30, 100);
            kind = $urandom_range(0, 9);
            if (kind == 0) begin
                enable = 1'b0;
                tick_pulse(1'b1);
                chk("disabled_rand", busy0, 0);
                enable = 1'b1;
            end else if (kind == 1) begin
                tick_pulse(1'b0);
                chk("tick_only_rand", busy0, 0);
            end else begin
                run_pass(5'($urandom_range(0, 31)), ready_pct == 100, kind == 2 && ready_pct == 100, 0);
            end
        end
        chk("seen_exit_clear", int'(clear_seen[0] > 0), 1);
        chk("seen_full_block", int'(full_seen[1] > 0), 1);

        // Reset in the middle of a stalled erase request.
        if (!abort) begin
            ready_pct = 0;
            begin
                int n0, n1;
                rand_in = 5'd3;
                model_pass(0, 3, n0);
                model_pass(1, 3, n1);
            end
            tick_pulse(1'b1);
            k = 0;
            while (!dv0 && k < 50) begin
                @(posedge clock);
                #1;
                k++;
            end
            chk("pre_reset_valid", dv0, 1);
            chk("pre_reset_erase", de0, 1);
            resetn = 1'b0;
            @(posedge clock);
            #1;
            chk("midrst_valid", dv0, 0);
            chk("midrst_x", dx0, 0);
            chk("midrst_lane", dl0, 0);
            chk("midrst_erase", de0, 0);
            chk("midrst_slots", sa0, 0);
            chk("midrst_busy", busy0, 0);
            chk("midrst_valid1", dv1, 0);
            chk("midrst_slots1", sa1, 0);
            chk("midrst_busy1", busy1, 0);
            model_reset();
            @(posedge clock);
            #1;
            resetn = 1'b1;
            ready_pct = 100;
            for (int p = 0; p < 12; p++) run_pass(5'($urandom_range(0, 31)), 1, 0, 0);
        end
        repeat (3) @(posedge clock);
        #1;
        chk("queue0_drained", q0.size(), 0);
        chk("queue1_drained", q1.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
